// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs, ALUOp codes,
// datapath mux selects and FSM state names.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;

    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADDU = 5'd1;
    localparam logic [4:0] ALUOP_SUBU = 5'd2;
    localparam logic [4:0] ALUOP_SLL  = 5'd3;
    localparam logic [4:0] ALUOP_SRL  = 5'd4;
    localparam logic [4:0] ALUOP_SLT  = 5'd5;
    localparam logic [4:0] ALUOP_BEQ  = 5'd6;
    localparam logic [4:0] ALUOP_BNE  = 5'd7;
    localparam logic [4:0] ALUOP_SLTI = 5'd8;
    localparam logic [4:0] ALUOP_ORI  = 5'd9;
    localparam logic [4:0] ALUOP_LW   = 5'd10;
    localparam logic [4:0] ALUOP_LUI  = 5'd11;
    localparam logic [4:0] ALUOP_SW   = 5'd12;
    localparam logic [4:0] ALUOP_J    = 5'd13;

    localparam logic REG_DST_RT = 1'b0;
    localparam logic REG_DST_RD = 1'b1;
    localparam logic EXT_ZERO   = 1'b0;
    localparam logic EXT_SIGNED = 1'b1;
    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_ALUOUT = 1'b1;
    localparam logic SRCA_PC = 1'b0;
    localparam logic SRCA_RS = 1'b1;

    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] MC_FETCH    = 4'd0;
    localparam logic [3:0] MC_DECODE   = 4'd1;
    localparam logic [3:0] MC_EXEC_R   = 4'd2;
    localparam logic [3:0] MC_EXEC_I   = 4'd3;
    localparam logic [3:0] MC_MEM_ADDR = 4'd4;
    localparam logic [3:0] MC_MEM_RD   = 4'd5;
    localparam logic [3:0] MC_MEM_WR   = 4'd6;
    localparam logic [3:0] MC_WB_MEM   = 4'd7;
    localparam logic [3:0] MC_WB_ALU   = 4'd8;
    localparam logic [3:0] MC_BRANCH   = 4'd9;
    localparam logic [3:0] MC_JUMP     = 4'd10;

    // Which post-decode path an instruction takes.
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_IALU,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP
    } iclass_e;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational instruction decode: OpCode/Funct to ALUOp, ExtOp, RegDst, class and legality.
module mc_alu_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] aluop,
    output logic               extop,
    output logic               regdst,
    output logic               legal,
    output iclass_e            iclass
);

    logic [4:0] op5;

    always_comb begin
        op5    = ALUOP_NOP;
        extop  = EXT_ZERO;
        regdst = REG_DST_RT;
        legal  = 1'b1;
        iclass = CLS_NONE;
        case (opcode)
            OP_RTYPE: begin
                iclass = CLS_RTYPE;
                regdst = REG_DST_RD;
                case (funct)
                    FUNCT_ADDU: op5 = ALUOP_ADDU;
                    FUNCT_SUBU: op5 = ALUOP_SUBU;
                    FUNCT_SLL:  op5 = ALUOP_SLL;
                    FUNCT_SRL:  op5 = ALUOP_SRL;
                    FUNCT_SLT:  op5 = ALUOP_SLT;
                    default: begin
                        legal  = 1'b0;
                        iclass = CLS_NONE;
                    end
                endcase
            end
            OP_SLTI: begin
                iclass = CLS_IALU;
                op5    = ALUOP_SLTI;
                extop  = EXT_SIGNED;
            end
            OP_ORI: begin
                iclass = CLS_IALU;
                op5    = ALUOP_ORI;
            end
            OP_LUI: begin
                iclass = CLS_IALU;
                op5    = ALUOP_LUI;
                extop  = EXT_SIGNED;
            end
            OP_LW: begin
                iclass = CLS_MEM;
                op5    = ALUOP_LW;
                extop  = EXT_SIGNED;
            end
            OP_SW: begin
                iclass = CLS_MEM;
                op5    = ALUOP_SW;
                extop  = EXT_SIGNED;
            end
            OP_BEQ: begin
                iclass = CLS_BRANCH;
                op5    = ALUOP_BEQ;
            end
            OP_BNE: begin
                iclass = CLS_BRANCH;
                op5    = ALUOP_BNE;
            end
            OP_J: begin
                iclass = CLS_JUMP;
                op5    = ALUOP_J;
            end
            default: legal = 1'b0;
        endcase
    end

    assign aluop = ALUOP_W'(op5);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over one ALU
// and one unified memory port, stalling on mem_ready.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic               IRWr,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               Mem2Reg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    logic [3:0]         state_q, state_d;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_extop;
    logic               dec_regdst;
    logic               dec_legal;
    iclass_e            dec_class;

    mc_alu_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_alu_decode (
        .opcode (OpCode),
        .funct  (Funct),
        .aluop  (dec_aluop),
        .extop  (dec_extop),
        .regdst (dec_regdst),
        .legal  (dec_legal),
        .iclass (dec_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = MC_FETCH;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        IorD     = IORD_PC;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = REG_DST_RT;
        Mem2Reg  = 1'b0;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = ALUSRCB_RT;
        ExtOp    = EXT_ZERO;
        ALUOp    = '0;
        PCSrc    = PCSRC_ALU;
        illegal  = 1'b0;

        case (state_q)
            MC_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUSRCB_FOUR;
                ALUOp   = ALUOP_W'(ALUOP_ADDU);
                if (mem_ready) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = MC_DECODE;
                end else begin
                    state_d = MC_FETCH;
                end
            end
            MC_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ALUSrcB = ALUSRCB_IMM_SL2;
                ExtOp   = EXT_SIGNED;
                ALUOp   = ALUOP_W'(ALUOP_ADDU);
                if (!dec_legal) begin
                    illegal = 1'b1;
                    state_d = MC_FETCH;
                end else begin
                    case (dec_class)
                        CLS_RTYPE:  state_d = MC_EXEC_R;
                        CLS_IALU:   state_d = MC_EXEC_I;
                        CLS_MEM:    state_d = MC_MEM_ADDR;
                        CLS_BRANCH: state_d = MC_BRANCH;
                        CLS_JUMP:   state_d = MC_JUMP;
                        default:    state_d = MC_FETCH;
                    endcase
                end
            end
            MC_EXEC_R: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = ALUSRCB_RT;
                ALUOp   = dec_aluop;
                state_d = MC_WB_ALU;
            end
            MC_EXEC_I: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = ALUSRCB_IMM;
                ExtOp   = dec_extop;
                ALUOp   = dec_aluop;
                state_d = MC_WB_ALU;
            end
            MC_MEM_ADDR: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = ALUSRCB_IMM;
                ExtOp   = EXT_SIGNED;
                ALUOp   = dec_aluop;
                state_d = (OpCode == OP_SW) ? MC_MEM_WR : MC_MEM_RD;
            end
            MC_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = IORD_ALUOUT;
                state_d = mem_ready ? MC_WB_MEM : MC_MEM_RD;
            end
            MC_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = IORD_ALUOUT;
                state_d  = mem_ready ? MC_FETCH : MC_MEM_WR;
            end
            MC_WB_MEM: begin
                RegWrite = 1'b1;
                RegDst   = REG_DST_RT;
                Mem2Reg  = 1'b1;
                state_d  = MC_FETCH;
            end
            MC_WB_ALU: begin
                // ALUOp held so ALUOut stays stable for the register write.
                RegWrite = 1'b1;
                RegDst   = dec_regdst;
                ALUOp    = dec_aluop;
                state_d  = MC_FETCH;
            end
            MC_BRANCH: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = ALUSRCB_RT;
                ALUOp   = dec_aluop;
                PCSrc   = PCSRC_ALUOUT;
                PCWr    = ((OpCode == OP_BEQ) && Zero) || ((OpCode == OP_BNE) && !Zero);
                state_d = MC_FETCH;
            end
            MC_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWr    = 1'b1;
                state_d = MC_FETCH;
            end
            default: state_d = MC_FETCH;
        endcase

        // Reset wins over everything so no write strobe escapes an aborted instruction.
        if (rst) begin
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            Mem2Reg  = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ExtOp    = 1'b0;
            ALUOp    = '0;
            PCSrc    = 2'b00;
            illegal  = 1'b0;
        end
    end

    assign state = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle control pattern and compares every cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode, Funct;
    logic       Zero, mem_ready;
    logic       PCWr, IRWr, IorD, MemRead, MemWrite, RegWrite, RegDst, Mem2Reg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       ExtOp, illegal;
    logic [4:0] ALUOp;
    logic [3:0] state;

    int total = 0;
    int bad = 0;
    int n_rw, n_mw, n_ir, n_ill;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .STATE_W (4),
        .ALUOP_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .OpCode    (OpCode),
        .Funct     (Funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .Mem2Reg   (Mem2Reg),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtOp     (ExtOp),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .state     (state),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcwr, irwr, iord, memread, memwrite, regwrite, regdst, mem2reg, srca;
        logic [1:0] srcb;
        logic       extop;
        logic [4:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } exp_t;

    typedef enum int {KR, KI, KLW, KSW, KBEQ, KBNE, KJ, KILL} kind_e;

    localparam logic [4:0] A_ADDU = 5'd1;

    logic [11:0] legal_tbl [13] = '{
        {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h2a},
        {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h0a, 6'h00}, {6'h0d, 6'h00}, {6'h23, 6'h00},
        {6'h0f, 6'h00}, {6'h2b, 6'h00}, {6'h02, 6'h00}
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Instruction set as listed: class, ALU operation and immediate extension.
    task automatic classify(input logic [5:0] op, input logic [5:0] fn, output kind_e k,
                            output logic [4:0] a, output logic ext);
        k = KILL; a = 5'd0; ext = 1'b0;
        case (op)
            6'h00: begin
                k = KR;
                case (fn)
                    6'h21: a = 5'd1;
                    6'h23: a = 5'd2;
                    6'h00: a = 5'd3;
                    6'h02: a = 5'd4;
                    6'h2a: a = 5'd5;
                    default: k = KILL;
                endcase
            end
            6'h04: begin k = KBEQ; a = 5'd6; end
            6'h05: begin k = KBNE; a = 5'd7; end
            6'h0a: begin k = KI; a = 5'd8; ext = 1'b1; end
            6'h0d: begin k = KI; a = 5'd9; ext = 1'b0; end
            6'h0f: begin k = KI; a = 5'd11; ext = 1'b1; end
            6'h23: begin k = KLW; a = 5'd10; end
            6'h2b: begin k = KSW; a = 5'd12; end
            6'h02: k = KJ;
            default: k = KILL;
        endcase
    endtask

    // Apply inputs for one cycle, compare at the falling edge, then advance past the rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic z, input exp_t e);
        logic [23:0] obs;
        OpCode = op; Funct = fn; mem_ready = rdy; Zero = z;
        @(negedge clk);
        obs = {state, PCWr, IRWr, IorD, MemRead, MemWrite, RegWrite, RegDst, Mem2Reg,
               ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, illegal};
        check_eq({tag, "/state"}, 32'(state), 32'(e.st));
        check_eq({tag, "/outs"}, 32'(obs), 32'(e));
        n_rw += int'(RegWrite);
        n_mw += int'(MemWrite);
        n_ir += int'(IRWr);
        n_ill += int'(illegal);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t fetch_exp(input logic rdy);
        exp_t e = '0;
        e.memread = 1'b1; e.srcb = 2'b01; e.aluop = A_ADDU;
        e.irwr = rdy; e.pcwr = rdy;
        return e;
    endfunction

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic zb);
        kind_e k;
        logic [4:0] a;
        logic ext;
        exp_t e;
        classify(op, fn, k, a, ext);
        n_rw = 0; n_mw = 0; n_ir = 0; n_ill = 0;
        for (int i = 0; i < wf; i++)
            step({tag, "/fetch_wait"}, 6'($urandom), 6'($urandom), 1'b0, 1'($urandom), fetch_exp(0));
        step({tag, "/fetch"}, 6'($urandom), 6'($urandom), 1'b1, 1'($urandom), fetch_exp(1));
        e = '0; e.st = 4'd1; e.srcb = 2'b11; e.extop = 1'b1; e.aluop = A_ADDU;
        e.ill = (k == KILL);
        step({tag, "/decode"}, op, fn, 1'($urandom), 1'($urandom), e);
        case (k)
            KR, KI: begin
                e = '0; e.st = (k == KR) ? 4'd2 : 4'd3; e.srca = 1'b1;
                e.srcb = (k == KR) ? 2'b00 : 2'b10; e.extop = (k == KI) ? ext : 1'b0;
                e.aluop = a;
                step({tag, "/exec"}, op, fn, 1'($urandom), 1'($urandom), e);
                e = '0; e.st = 4'd8; e.regwrite = 1'b1; e.regdst = (k == KR); e.aluop = a;
                step({tag, "/wb_alu"}, op, fn, 1'($urandom), 1'($urandom), e);
            end
            KLW, KSW: begin
                e = '0; e.st = 4'd4; e.srca = 1'b1; e.srcb = 2'b10; e.extop = 1'b1; e.aluop = a;
                step({tag, "/mem_addr"}, op, fn, 1'($urandom), 1'($urandom), e);
                e = '0; e.iord = 1'b1;
                if (k == KLW) begin e.st = 4'd5; e.memread = 1'b1; end
                else begin e.st = 4'd6; e.memwrite = 1'b1; end
                for (int i = 0; i < wm; i++)
                    step({tag, "/mem_wait"}, op, fn, 1'b0, 1'($urandom), e);
                step({tag, "/mem"}, op, fn, 1'b1, 1'($urandom), e);
                if (k == KLW) begin
                    e = '0; e.st = 4'd7; e.regwrite = 1'b1; e.mem2reg = 1'b1;
                    step({tag, "/wb_mem"}, op, fn, 1'($urandom), 1'($urandom), e);
                end
            end
            KBEQ, KBNE: begin
                e = '0; e.st = 4'd9; e.srca = 1'b1; e.aluop = a; e.pcsrc = 2'b01;
                e.pcwr = (k == KBEQ) ? zb : !zb;
                step({tag, "/branch"}, op, fn, 1'($urandom), zb, e);
            end
            KJ: begin
                e = '0; e.st = 4'd10; e.pcsrc = 2'b10; e.pcwr = 1'b1;
                step({tag, "/jump"}, op, fn, 1'($urandom), 1'($urandom), e);
            end
            default: ;
        endcase
        check_eq({tag, "/irwr_cnt"}, 32'(n_ir), 32'd1);
        check_eq({tag, "/regwr_cnt"}, 32'(n_rw), (k == KR || k == KI || k == KLW) ? 32'd1 : 32'd0);
        check_eq({tag, "/memwr_cnt"}, 32'(n_mw), (k == KSW) ? 32'(wm + 1) : 32'd0);
        check_eq({tag, "/illegal_cnt"}, 32'(n_ill), (k == KILL) ? 32'd1 : 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [11:0] pick;
        rst = 1'b1; OpCode = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset", 6'h23, 6'h21, 1'b1, 1'b1, '0);
        rst = 1'b0;

        run_instr("addu", 6'h00, 6'h21, 0, 0, 1'b0);
        run_instr("lw_wait", 6'h23, 6'h00, 2, 1, 1'b0);
        run_instr("beq_z1", 6'h04, 6'h00, 0, 0, 1'b1);
        run_instr("bne_z1", 6'h05, 6'h00, 0, 0, 1'b1);
        run_instr("bne_z0", 6'h05, 6'h00, 0, 0, 1'b0);
        run_instr("sw_wait", 6'h2b, 6'h00, 0, 3, 1'b0);
        run_instr("ill_op", 6'h3f, 6'h00, 0, 0, 1'b0);
        run_instr("ill_fn", 6'h00, 6'h3f, 0, 0, 1'b0);
        run_instr("ori", 6'h0d, 6'h00, 1, 0, 1'b0);
        run_instr("j", 6'h02, 6'h00, 0, 0, 1'b0);

        // Reset while a store is stalled in its memory cycle.
        step("rst_sw/fetch", 6'h00, 6'h00, 1'b1, 1'b0, fetch_exp(1));
        e = '0; e.st = 4'd1; e.srcb = 2'b11; e.extop = 1'b1; e.aluop = A_ADDU;
        step("rst_sw/decode", 6'h2b, 6'h00, 1'b0, 1'b0, e);
        e = '0; e.st = 4'd4; e.srca = 1'b1; e.srcb = 2'b10; e.extop = 1'b1; e.aluop = 5'd12;
        step("rst_sw/mem_addr", 6'h2b, 6'h00, 1'b0, 1'b0, e);
        e = '0; e.st = 4'd6; e.iord = 1'b1; e.memwrite = 1'b1;
        step("rst_sw/mem_wr", 6'h2b, 6'h00, 1'b0, 1'b0, e);
        rst = 1'b1;
        step("rst_sw/abort", 6'h2b, 6'h00, 1'b1, 1'b0, '0);
        rst = 1'b0;
        step("rst_sw/after", 6'h2b, 6'h00, 1'b0, 1'b0, fetch_exp(0));
        run_instr("post_rst", 6'h0a, 6'h00, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(9) < 8) begin
                pick = legal_tbl[$urandom_range(12)];
                if (pick[11:6] != 6'h00) pick[5:0] = 6'($urandom);
            end else begin
                pick = 12'($urandom);
            end
            run_instr($sformatf("rnd%0d", n), pick[11:6], pick[5:0],
                      int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
